// File: rtl/nd_2to1.sv
// Two-input, one-output message merger with per-input FIFOs and a round-robin arbiter.
// All three channels use a four-phase req/ack handshake.
module nd_2to1 #(
    parameter int unsigned FSZ = 2,
    parameter int unsigned ASZ = 6,
    parameter int unsigned DSZ = 4,
    parameter int unsigned RSZ = 4
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack
);

    localparam int unsigned IW = $clog2(FSZ);
    localparam int unsigned MW = 2 * ASZ + DSZ + RSZ;
    localparam logic [IW:0] CntFull = (IW + 1)'(FSZ);

    typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

    state_e state_q, state_d;

    logic [MW-1:0] mem0 [FSZ];
    logic [MW-1:0] mem1 [FSZ];
    logic [IW-1:0] head0_q, tail0_q, head1_q, tail1_q;
    logic [IW:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic last_q;   // 1: bf1 served last, so bf0 wins the next tie
    logic sel_q, sel_d;
    logic full0, full1, ne0, ne1;
    logic cap0, cap1, pop0, pop1, load;
    logic [MW-1:0] msg_sel;

    assign full0 = (cnt0_q == CntFull);
    assign full1 = (cnt1_q == CntFull);
    assign ne0   = (cnt0_q != '0);
    assign ne1   = (cnt1_q != '0);

    // Full is taken from registered state, so a same-cycle pop never frees room for a capture.
    assign cap0 = ready && rcv0_req && !rcv0_ack && !full0;
    assign cap1 = ready && rcv1_req && !rcv1_ack && !full1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        load    = 1'b0;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            StIdle: begin
                if (ready && (ne0 || ne1)) begin
                    load    = 1'b1;
                    sel_d   = (ne0 && ne1) ? ~last_q : ne1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (snd0_ack) begin
                    pop0    = ~sel_q;
                    pop1    = sel_q;
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!snd0_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign msg_sel = sel_d ? mem1[tail1_q] : mem0[tail0_q];

    always_comb begin
        cnt0_d = cnt0_q;
        case ({cap0, pop0})
            2'b10:   cnt0_d = cnt0_q + 1'b1;
            2'b01:   cnt0_d = cnt0_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt1_d = cnt1_q;
        case ({cap1, pop1})
            2'b10:   cnt1_d = cnt1_q + 1'b1;
            2'b01:   cnt1_d = cnt1_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset || !ready) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready    <= 1'b0;
            snd0_req <= 1'b0;
            rcv0_ack <= 1'b0;
            rcv1_ack <= 1'b0;
        end else if (!ready) begin
            ready    <= 1'b1;
            snd0_req <= 1'b0;
            rcv0_ack <= 1'b0;
            rcv1_ack <= 1'b0;
            head0_q  <= '0;
            tail0_q  <= '0;
            cnt0_q   <= '0;
            head1_q  <= '0;
            tail1_q  <= '0;
            cnt1_q   <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            snd0_src <= '0;
            snd0_dst <= '0;
            snd0_dat <= '0;
            snd0_red <= '0;
        end else begin
            sel_q  <= sel_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;

            if (load) begin
                {snd0_src, snd0_dst, snd0_dat, snd0_red} <= msg_sel;
                snd0_req <= 1'b1;
            end
            if (state_q == StReq && snd0_ack) begin
                snd0_req <= 1'b0;
                last_q   <= sel_q;
            end

            if (cap0) begin
                head0_q  <= head0_q + 1'b1;
                rcv0_ack <= 1'b1;
            end else if (rcv0_ack && !rcv0_req) begin
                rcv0_ack <= 1'b0;
            end
            if (cap1) begin
                head1_q  <= head1_q + 1'b1;
                rcv1_ack <= 1'b1;
            end else if (rcv1_ack && !rcv1_req) begin
                rcv1_ack <= 1'b0;
            end

            if (pop0) tail0_q <= tail0_q + 1'b1;
            if (pop1) tail1_q <= tail1_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset && cap0) mem0[head0_q] <= {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
        if (!reset && cap1) mem1[head1_q] <= {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};
    end

endmodule

// File: tb/tb_nd_2to1.sv
// Randomised bench for nd_2to1: queue-based scoreboard, handshake timing and reset checks.
module tb_nd_2to1;

    localparam int ASZ = 6;
    localparam int DSZ = 4;
    localparam int RSZ = 4;
    localparam int W   = 2 * ASZ + DSZ + RSZ;

    logic i_clk = 1'b0;
    logic reset = 1'b1;
    logic ready;
    logic [ASZ-1:0] rcv0_src = '0, rcv0_dst = '0, rcv1_src = '0, rcv1_dst = '0;
    logic [DSZ-1:0] rcv0_dat = '0, rcv1_dat = '0;
    logic [RSZ-1:0] rcv0_red = '0, rcv1_red = '0;
    logic rcv0_req = 1'b0, rcv1_req = 1'b0;
    logic rcv0_ack, rcv1_ack;
    logic [ASZ-1:0] snd0_src, snd0_dst;
    logic [DSZ-1:0] snd0_dat;
    logic [RSZ-1:0] snd0_red;
    logic snd0_req;
    logic snd0_ack = 1'b0;

    nd_2to1 #(.FSZ(2), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .ready    (ready),
        .rcv0_src (rcv0_src),
        .rcv0_dst (rcv0_dst),
        .rcv0_dat (rcv0_dat),
        .rcv0_red (rcv0_red),
        .rcv0_req (rcv0_req),
        .rcv0_ack (rcv0_ack),
        .rcv1_src (rcv1_src),
        .rcv1_dst (rcv1_dst),
        .rcv1_dat (rcv1_dat),
        .rcv1_red (rcv1_red),
        .rcv1_req (rcv1_req),
        .rcv1_ack (rcv1_ack),
        .snd0_src (snd0_src),
        .snd0_dst (snd0_dst),
        .snd0_dat (snd0_dat),
        .snd0_red (snd0_red),
        .snd0_req (snd0_req),
        .snd0_ack (snd0_ack)
    );

    always #5 i_clk = ~i_clk;

    logic [W-1:0] snd_msg;
    assign snd_msg = {snd0_src, snd0_dst, snd0_dat, snd0_red};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-input queues of accepted messages, in acceptance order.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] out_log[$];
    bit hold = 1'b0;
    int fixed_dly = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source address MSB carries the channel number so the scoreboard knows the origin.
    function automatic logic [W-1:0] mk(input int ch);
        logic [ASZ-1:0] s;
        s = ASZ'($urandom);
        s[ASZ-1] = ch[0];
        return {s, ASZ'($urandom), DSZ'($urandom), RSZ'($urandom)};
    endfunction

    function automatic logic ack_of(input int ch);
        return (ch == 0) ? rcv0_ack : rcv1_ack;
    endfunction

    task automatic send(input int ch, input logic [W-1:0] m, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        if (ch == 0) begin
            {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
            rcv0_req = 1'b1;
        end else begin
            {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = m;
            rcv1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!ack_of(ch) && n < budget);
        if (ack_of(ch)) begin
            ok = 1'b1;
            if (ch == 0) q0.push_back(m);
            else q1.push_back(m);
        end else begin
            check("ack_timeout", 32'(ch), 32'hffff);
        end
        if (ch == 0) rcv0_req = 1'b0;
        else rcv1_req = 1'b0;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (ack_of(ch) && n < 10);
        if (ack_of(ch)) check("ack_fall", 32'(ack_of(ch)), 32'h0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || snd0_req || snd0_ack) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("drain", 32'(n < budget), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        reset = 1'b1;
        repeat (2) @(negedge i_clk);
        reset = 1'b0;
        @(negedge i_clk);
        q0.delete();
        q1.delete();
        out_log.delete();
    endtask

    // Output responder: acks after a delay and checks content, order and field stability.
    initial begin
        logic [W-1:0] m;
        int d;
        int n;
        forever begin
            @(negedge i_clk);
            if (snd0_req && !snd0_ack && !hold) begin
                m = snd_msg;
                out_log.push_back(m);
                if (m[W-1] == 1'b0) begin
                    if (q0.size() == 0) check("sb_extra0", 32'(m), 32'hdead);
                    else check("sb_order0", 32'(m), 32'(q0.pop_front()));
                end else begin
                    if (q1.size() == 0) check("sb_extra1", 32'(m), 32'hdead);
                    else check("sb_order1", 32'(m), 32'(q1.pop_front()));
                end
                d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
                for (int i = 0; i < d; i++) begin
                    @(negedge i_clk);
                    check("req_held", 32'(snd0_req), 32'h1);
                    check("stable_req", 32'(snd_msg), 32'(m));
                end
                snd0_ack = 1'b1;
                n = 0;
                do begin
                    @(negedge i_clk);
                    n++;
                    check("stable_wl", 32'(snd_msg), 32'(m));
                end while (snd0_req && n < 20);
                check("req_fall", 32'(snd0_req), 32'h0);
                snd0_ack = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] m, a0, a1, b0, b1;
        logic [W-1:0] exp4 [4];
        bit ok0, ok1, ok2, ok3;

        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_req", 32'(snd0_req), 32'h0);
        check("rst_ack0", 32'(rcv0_ack), 32'h0);
        check("rst_ack1", 32'(rcv1_ack), 32'h0);
        reset = 1'b0;
        @(negedge i_clk);
        check("init_ready", 32'(ready), 32'h1);

        // Single message latency on rcv0
        fixed_dly = 1;
        m = {1'b0, 5'd1, 6'd5, 4'd3, 4'($urandom)};
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
        rcv0_req = 1'b1;
        @(negedge i_clk);
        check("lat_ack", 32'(rcv0_ack), 32'h1);
        check("lat_noreq", 32'(snd0_req), 32'h0);
        q0.push_back(m);
        rcv0_req = 1'b0;
        @(negedge i_clk);
        check("lat_req", 32'(snd0_req), 32'h1);
        check("lat_dst", 32'(snd0_dst), 32'h5);
        check("lat_dat", 32'(snd0_dat), 32'h3);
        wait_drain(50);
        check("ack0_clear", 32'(rcv0_ack), 32'h0);

        // Simultaneous fill, round-robin order A0,B0,A1,B1
        do_reset();
        fixed_dly = 0;
        hold = 1'b1;
        a0 = mk(0); a1 = mk(0); b0 = mk(1); b1 = mk(1);
        fork
            begin send(0, a0, 20, ok0); send(0, a1, 20, ok1); end
            begin send(1, b0, 20, ok2); send(1, b1, 20, ok3); end
        join
        check("rr_acc", {28'h0, ok0, ok1, ok2, ok3}, 32'hf);
        hold = 1'b0;
        wait_drain(100);
        exp4[0] = a0; exp4[1] = b0; exp4[2] = a1; exp4[3] = b1;
        check("rr_cnt", 32'(out_log.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_log.size()) check("rr_order", 32'(out_log[i]), 32'(exp4[i]));
        end

        // Back-pressure: third message on rcv1 must wait for a free slot
        do_reset();
        hold = 1'b1;
        a0 = mk(1); a1 = mk(1); b0 = mk(1);
        send(1, a0, 20, ok0);
        send(1, a1, 20, ok1);
        fork
            send(1, b0, 60, ok2);
            begin
                repeat (6) @(negedge i_clk);
                check("full_noack", 32'(rcv1_ack), 32'h0);
                hold = 1'b0;
            end
        join
        check("full_acked", {29'h0, ok0, ok1, ok2}, 32'h7);
        wait_drain(100);
        exp4[0] = a0; exp4[1] = a1; exp4[2] = b0;
        check("full_cnt", 32'(out_log.size()), 32'h3);
        for (int i = 0; i < 3; i++) begin
            if (i < out_log.size()) check("full_order", 32'(out_log[i]), 32'(exp4[i]));
        end

        // Slow ack: fields stable through REQ and WAIT_LOW
        do_reset();
        fixed_dly = 5;
        send(0, mk(0), 20, ok0);
        wait_drain(100);
        check("slow_cnt", 32'(out_log.size()), 32'h1);

        // Reset during REQ with both FIFOs holding data
        do_reset();
        hold = 1'b1;
        fixed_dly = -1;
        fork
            begin send(0, mk(0), 20, ok0); send(0, mk(0), 20, ok1); end
            begin send(1, mk(1), 20, ok2); send(1, mk(1), 20, ok3); end
        join
        @(negedge i_clk);
        check("pre_rst_req", 32'(snd0_req), 32'h1);
        reset = 1'b1;
        @(negedge i_clk);
        check("mid_rst_req", 32'(snd0_req), 32'h0);
        check("mid_rst_ack0", 32'(rcv0_ack), 32'h0);
        check("mid_rst_ack1", 32'(rcv1_ack), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h0);
        reset = 1'b0;
        @(negedge i_clk);
        check("rel_ready", 32'(ready), 32'h1);
        q0.delete();
        q1.delete();
        out_log.delete();
        hold = 1'b0;
        repeat (20) @(negedge i_clk);
        check("no_stale_req", 32'(snd0_req), 32'h0);
        check("no_stale_out", 32'(out_log.size()), 32'h0);

        // Random back-to-back traffic on both inputs
        do_reset();
        fixed_dly = -1;
        fork
            begin
                bit okr;
                for (int i = 0; i < 40; i++) begin
                    send(0, mk(0), 200, okr);
                    repeat ($urandom_range(0, 2)) @(negedge i_clk);
                end
            end
            begin
                bit okr;
                for (int i = 0; i < 40; i++) begin
                    send(1, mk(1), 200, okr);
                    repeat ($urandom_range(0, 2)) @(negedge i_clk);
                end
            end
        join
        wait_drain(3000);
        check("rand_cnt", 32'(out_log.size()), 32'd80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nd_2to1.md
ND_2TO1 -- requirements
Module: nd_2to1

Interface
REQ-001 Parameter FSZ, default 2, depth in messages of each per-input FIFO (power of two, >=2).
REQ-002 Parameter ASZ, default 6, width of src and dst address fields.
REQ-003 Parameter DSZ, default 4, width of data field.
REQ-004 Parameter RSZ, default 4, width of redundancy field.
REQ-005 i_clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ready  out  1  high once initialisation completes after reset.
REQ-008 rcv0_src/rcv0_dst  in  ASZ each; rcv0_dat  in  DSZ; rcv0_red  in  RSZ; message on input channel 0.
REQ-009 rcv0_req  in  1; rcv0_ack  out  1; four-phase handshake for input channel 0.
REQ-010 rcv1_src, rcv1_dst, rcv1_dat, rcv1_red, rcv1_req, rcv1_ack: same as REQ-008/009 for input channel 1.
REQ-011 snd0_src/snd0_dst  out  ASZ each; snd0_dat  out  DSZ; snd0_red  out  RSZ; merged output message.
REQ-012 snd0_req  out  1; snd0_ack  in  1; four-phase handshake for the output channel.

Function
REQ-013 Block SHALL merge two input channels into one output, each message forwarded unmodified (all four fields), exactly once.
REQ-014 Each input SHALL have a private FIFO bfN of FSZ entries with head/tail indices of $clog2(FSZ) bits wrapping modulo FSZ, plus a count/full flag distinguishing full from empty.
REQ-015 Input capture: when rcvN_req=1, rcvN_ack=0 and bfN not full, message SHALL be written at head, head advanced, rcvN_ack set on the next edge.
REQ-016 rcvN_ack SHALL hold 1 until rcvN_req is sampled 0, then clear on the next edge; no new capture on channel N while rcvN_ack=1.
REQ-017 When bfN is full, rcvN_ack SHALL stay 0 and the request remain pending; no data lost or overwritten.
REQ-018 Both inputs SHALL be capturable in the same cycle (independent FIFOs).
REQ-019 Output FSM states: IDLE, REQ (snd0_req=1 awaiting snd0_ack=1), WAIT_LOW (snd0_req=0 awaiting snd0_ack=0).
REQ-020 IDLE: if either FIFO non-empty, select source, load output registers from its tail, set snd0_req, go REQ.
REQ-021 Selection: only one non-empty -> that one; both non-empty -> the FIFO not served last (round-robin); last-served flag resets to 1 so bf0 wins the first tie.
REQ-022 REQ: on snd0_ack=1 clear snd0_req, advance selected FIFO tail, update last-served, go WAIT_LOW.
REQ-023 WAIT_LOW: on snd0_ack=0 go IDLE; next message earliest one edge later.
REQ-024 snd0_src/dst/dat/red SHALL remain stable from req rise until ack falls.
REQ-025 A FIFO entry SHALL be freed (tail advance) in the same edge as REQ->WAIT_LOW; a simultaneous capture into a full FIFO is not permitted that cycle (full evaluated on registered state).
REQ-026 Latency: rcvN_req sampled at edge k -> rcvN_ack at k+1; earliest snd0_req at k+2 for an idle, empty block.
REQ-027 Per-input ordering SHALL be preserved; no cross-channel ordering guarantee beyond REQ-021.

Reset
REQ-028 While reset=1 at an edge: ready SHALL become 0; ready, snd0_req, rcv0_ack, rcv1_ack reset value 0.
REQ-029 First edge with reset=0 and ready=0: clear FIFO indices/counts, output registers to 0, FSM to IDLE, last-served to 1, acks 0; set ready=1.
REQ-030 No capture or output activity while ready=0; reset mid-handshake aborts it, discarding all buffered messages.

Verification
REQ-031 Reset then single message on rcv0 (dst=5,dat=3) -> rcv0_ack at k+1, snd0_req at k+2 with dst=5,dat=3; full four-phase completes.
REQ-032 Both inputs fill simultaneously with 2 each (A0,A1 / B0,B1), snd0_ack responsive -> output order A0,B0,A1,B1.
REQ-033 snd0_ack held 0, send 3 on rcv1 with FSZ=2 -> two acked, third req stays unacked until one output completes, then acked; no loss.
REQ-034 Drive snd0_ack high only after 5 cycles -> snd0 fields stable throughout REQ and WAIT_LOW.
REQ-035 Assert reset during REQ with both FIFOs holding data -> snd0_req, acks, ready 0; ready 1 one edge after release; no stale message emitted.
REQ-036 Random back-to-back traffic on both inputs, random ack delays 0-4 -> scoreboard: every message out once, per-input order kept.
